pusher_arbiter: RTL
===================

PUSHER_ARBITER -- requirements
Module: pusher_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of upstream pusher channels (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, item width in bits.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive items accepted per grant (1..15).
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester item-valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-008 SHALL have port req_data  input  NUM_REQ*WIDTH  flattened items; requester i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port out_valid  output  1  output item valid.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port out_data  output  WIDTH  output item.
REQ-012 SHALL have port out_src  output  clog2(NUM_REQ)  index of requester that supplied out_data.
REQ-013 SHALL have port busy  output  1  high when state is GRANT or out_valid is high.

Function
REQ-014 SHALL implement FSM with states IDLE and GRANT, plus registers grant (index), last_grant (index), burst_cnt (4 bits).
REQ-015 IDLE: if any req_valid bit is high, SHALL select the first valid requester scanning last_grant+1, last_grant+2, ... modulo NUM_REQ, load grant and last_grant with it, clear burst_cnt, enter GRANT next cycle; no item accepted in IDLE.
REQ-016 req_ready[i] SHALL be high only when state==GRANT, i==grant, and (out_valid==0 or out_ready==1).
REQ-017 An accept (req_valid[grant] and req_ready[grant]) SHALL load out_data from the granted slice, out_src from grant, set out_valid, and increment burst_cnt, all on the same edge.
REQ-018 Latency from accept to out_valid SHALL be exactly 1 cycle; full throughput of 1 item/cycle SHALL be sustained within a grant while out_ready stays high.
REQ-019 out_valid, out_data and out_src SHALL hold stable while out_valid==1 and out_ready==0.
REQ-020 out_valid SHALL clear on an edge where out_ready==1 and no accept occurs.
REQ-021 GRANT -> IDLE SHALL occur on an accept that makes burst_cnt reach MAX_BURST.
REQ-022 GRANT -> IDLE SHALL occur in any cycle where req_valid[grant]==0, regardless of out_ready.
REQ-023 Changes to req_valid of non-granted requesters SHALL have no effect while in GRANT.
REQ-024 A requester dropping req_valid while its ready is low (output stalled) SHALL release the grant without any item loss or duplication.
REQ-025 With a single requester continuously valid, the pattern SHALL be MAX_BURST accepts, one IDLE cycle, re-grant of the same requester.

Reset
REQ-026 On a clock edge with reset==0: state=IDLE, grant=0, last_grant=NUM_REQ-1, burst_cnt=0, out_valid=0, out_data=0, out_src=0; req_ready=0 and busy=0 the following cycle.
REQ-027 Reset mid-operation SHALL discard any buffered output item and any partial burst; no item SHALL be presented after reset deasserts until a new accept.

Structure
REQ-028 Shared package pusher_arb_pkg SHALL hold the state enumeration (IDLE, GRANT) and the burst-counter width constant (4).
REQ-029 Round-robin selection SHALL be a separate combinational sub-module pusher_rr_pick (inputs: request vector, last_grant; outputs: found, index).
REQ-030 Total RTL SHALL be 120-400 lines; no latches, no combinational path from out_ready to out_valid.

Verification
REQ-031 Reset release, req_valid=4'b0001, data 0x11,0x22: IDLE 1 cycle, then out_data 0x11 then 0x22 on consecutive cycles, out_src=0.
REQ-032 All four requesters valid continuously, out_ready=1, MAX_BURST=4: grant order 0,1,2,3,0 with 4 items each and one IDLE bubble between grants.
REQ-033 out_ready=0 for 5 cycles after first accept of data 0xA5: out_data stays 0xA5, req_ready all 0, no further accepts; resumes with next item 1 cycle after out_ready=1.
REQ-034 Granted requester 2 drops req_valid after 2 items while requester 3 valid: FSM returns to IDLE, requester 3 granted next, exactly 2 items from requester 2 observed.
REQ-035 reset=0 asserted while out_valid=1 with data 0x5A mid-burst: out_valid=0 next cycle, 0x5A never accepted downstream, first grant after reset goes to requester 0 if valid.
REQ-036 Random valid/ready stimulus over 10k cycles: scoreboard per-requester in-order delivery, no loss/duplication, req_ready one-hot-or-zero every cycle.

Source files
------------

// File: rtl/pusher_arb_pkg.sv
// rtl/pusher_arb_pkg.sv - shared state encoding and counter width for the pusher arbiter
package pusher_arb_pkg;
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int BURST_W = 4;
endpackage

// File: rtl/pusher_rr_pick.sv
// rtl/pusher_rr_pick.sv - combinational round-robin pick starting after last_grant
module pusher_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_grant,
   output logic               found,
   output logic [IW-1:0]      index
);
   logic [IW-1:0] pos;

   // Offset 1 first so the previous owner is considered last.
   always_comb begin
      found = 1'b0;
      index = '0;
      pos   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos = IW'((int'(last_grant) + k) % NUM_REQ);
         if (!found && req[pos]) begin
            found = 1'b1;
            index = pos;
         end
      end
   end
endmodule

// File: rtl/pusher_arbiter.sv
// rtl/pusher_arbiter.sv - round-robin burst arbiter merging pusher channels into one registered stream
module pusher_arbiter
   import pusher_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(NUM_REQ)-1:0] out_src,
   output logic                       busy
);
   localparam int IW = $clog2(NUM_REQ);

   arb_state_t         state;
   logic [IW-1:0]      grant;
   logic [IW-1:0]      last_grant;
   logic [BURST_W-1:0] burst_cnt;
   logic [BURST_W-1:0] burst_next;
   logic               found;
   logic [IW-1:0]      pick;
   logic               out_free;
   logic               accept;

   pusher_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .found      (found),
      .index      (pick)
   );

   // The output register frees up in the same cycle it drains, giving 1 item/cycle.
   assign out_free   = !out_valid || out_ready;
   assign accept     = (state == GRANT) && out_free && req_valid[grant];
   assign burst_next = burst_cnt + BURST_W'(1);
   assign busy       = (state == GRANT) || out_valid;

   always_comb begin
      req_ready = '0;
      if (state == GRANT && out_free) begin
         req_ready[grant] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= IW'(NUM_REQ - 1);
         burst_cnt  <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant      <= pick;
                  last_grant <= pick;
                  burst_cnt  <= '0;
                  state      <= GRANT;
               end
            end
            GRANT: begin
               // A requester dropping valid gives up its grant even if the output is stalled.
               if (!req_valid[grant]) begin
                  state <= IDLE;
               end else if (accept) begin
                  burst_cnt <= burst_next;
                  if (burst_next == BURST_W'(MAX_BURST)) begin
                     state <= IDLE;
                  end
               end
            end
         endcase

         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= req_data[int'(grant)*WIDTH +: WIDTH];
            out_src   <= grant;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule
